// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM port arbiter (CPU bus vs. data_io download writer).
package sdram_arb_pkg;

  localparam int ADDR_W       = 23;
  localparam int TIMEOUT_DEF  = 64;
  localparam int DL_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    GR_CPU = 1'b0,
    GR_DL  = 1'b1
  } grant_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } dl_entry_t;

endpackage

// File: rtl/sdram_arb_fifo.sv
// Download write buffer: power-of-2 deep FIFO with show-ahead head entry.
module sdram_arb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the byte-wide SDRAM command port between the CPU bus and the download writer.
// SDRAM_ARB_DL_FIFO_EN selects a DL_DEPTH-entry download FIFO instead of one holding register.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW          = ADDR_W,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int DL_DEPTH    = DL_DEPTH_DEF
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [7:0]    cpu_din_i,
  input  logic          cpu_rd_i,
  input  logic          cpu_wr_i,
  output logic [7:0]    cpu_dout_o,
  output logic          cpu_ack_o,
  input  logic          dl_wr_i,
  input  logic [AW-1:0] dl_addr_i,
  input  logic [7:0]    dl_data_i,
  output logic          dl_busy_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_din_o,
  output logic          mem_rd_o,
  output logic          mem_we_o,
  input  logic [7:0]    mem_dout_i,
  input  logic          mem_ready_i,
  output logic          err_o,
  output logic          ovf_o,
  output arb_state_t    dbg_state_o
);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  // Handshakes: the CPU holds rd/wr until the one-cycle cpu_ack_o; a download byte is accepted
  // on any dl_wr_i cycle with dl_busy_o low; the SDRAM gets a one-cycle strobe and answers with
  // a one-cycle mem_ready_i, which only counts while in WAIT.
  arb_state_t    state, state_nxt;
  grant_t        grant_q, last_grant, sel;
  logic          start, finish, timed_out;
  logic          cpu_req, dl_req;
  logic [TW-1:0] timer;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_din;
  logic          cmd_we;
  dl_entry_t     push_entry, head_entry;
  logic          buf_full, buf_empty, push, pop;

  assign push_entry = '{addr: dl_addr_i, data: dl_data_i};
  assign push       = dl_wr_i & ~buf_full;
  assign pop        = finish & (grant_q == GR_DL);
  assign dl_busy_o  = buf_full;

`ifdef SDRAM_ARB_DL_FIFO_EN
  sdram_arb_fifo #(
    .W     ($bits(dl_entry_t)),
    .DEPTH (DL_DEPTH)
  ) u_dl_fifo (
    .clk   (clock_i),
    .rst_n (reset_n_i),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (buf_full),
    .empty (buf_empty)
  );
`else
  logic      hold_valid;
  dl_entry_t hold_q;

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      hold_valid <= 1'b0;
      hold_q     <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_q     <= push_entry;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign buf_full   = hold_valid;
  assign buf_empty  = ~hold_valid;
  assign head_entry = hold_q;
`endif

  // The CPU request is masked during its own ack cycle so a still-held level is not reissued.
  assign cpu_req = (cpu_rd_i | cpu_wr_i) & ~cpu_ack_o;
  assign dl_req  = ~buf_empty;

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    sel       = GR_CPU;
    case (state)
      IDLE: begin
        if (cpu_req || dl_req) begin
          start     = 1'b1;
          state_nxt = CMD;
          if (cpu_req && dl_req) sel = (last_grant == GR_CPU) ? GR_DL : GR_CPU;
          else                   sel = cpu_req ? GR_CPU : GR_DL;
        end
      end
      CMD: state_nxt = WAIT;
      WAIT: begin
        if (mem_ready_i) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      grant_q    <= GR_CPU;
      last_grant <= GR_DL;
      timer      <= '0;
      cmd_addr   <= '0;
      cmd_din    <= '0;
      cmd_we     <= 1'b0;
      cpu_ack_o  <= 1'b0;
      cpu_dout_o <= 8'h00;
      err_o      <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      cpu_ack_o <= 1'b0;
      timer     <= (state == WAIT) ? timer + 1'b1 : '0;
      if (start) begin
        grant_q    <= sel;
        last_grant <= sel;
        if (sel == GR_CPU) begin
          cmd_addr <= cpu_addr_i;
          cmd_din  <= cpu_din_i;
          cmd_we   <= cpu_wr_i;
        end else begin
          cmd_addr <= head_entry.addr;
          cmd_din  <= head_entry.data;
          cmd_we   <= 1'b1;
        end
      end
      if (finish && grant_q == GR_CPU) begin
        cpu_ack_o <= 1'b1;
        if (!cmd_we) cpu_dout_o <= timed_out ? 8'hFF : mem_dout_i;
      end
      if (timed_out)           err_o <= 1'b1;
      if (dl_wr_i && buf_full) ovf_o <= 1'b1;
    end
  end

  assign mem_addr_o  = cmd_addr;
  assign mem_din_o   = cmd_din;
  assign mem_rd_o    = (state == CMD) & ~cmd_we;
  assign mem_we_o    = (state == CMD) & cmd_we;
  assign dbg_state_o = state;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed + randomized bench for sdram_port_arbiter with a transaction-level SDRAM/CPU model.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int TMO = 64;
`ifdef SDRAM_ARB_DL_FIFO_EN
  localparam int BUF = 4;
`else
  localparam int BUF = 1;
`endif

  logic        clock_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [22:0] cpu_addr_i = '0;
  logic [7:0]  cpu_din_i = '0;
  logic        cpu_rd_i = 1'b0;
  logic        cpu_wr_i = 1'b0;
  logic [7:0]  cpu_dout_o;
  logic        cpu_ack_o;
  logic        dl_wr_i = 1'b0;
  logic [22:0] dl_addr_i = '0;
  logic [7:0]  dl_data_i = '0;
  logic        dl_busy_o;
  logic [22:0] mem_addr_o;
  logic [7:0]  mem_din_o;
  logic        mem_rd_o;
  logic        mem_we_o;
  logic [7:0]  mem_dout_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        err_o;
  logic        ovf_o;
  arb_state_t  dbg_state_o;

  sdram_port_arbiter dut (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_din_i   (cpu_din_i),
    .cpu_rd_i    (cpu_rd_i),
    .cpu_wr_i    (cpu_wr_i),
    .cpu_dout_o  (cpu_dout_o),
    .cpu_ack_o   (cpu_ack_o),
    .dl_wr_i     (dl_wr_i),
    .dl_addr_i   (dl_addr_i),
    .dl_data_i   (dl_data_i),
    .dl_busy_o   (dl_busy_o),
    .mem_addr_o  (mem_addr_o),
    .mem_din_o   (mem_din_o),
    .mem_rd_o    (mem_rd_o),
    .mem_we_o    (mem_we_o),
    .mem_dout_i  (mem_dout_i),
    .mem_ready_i (mem_ready_i),
    .err_o       (err_o),
    .ovf_o       (ovf_o),
    .dbg_state_o (dbg_state_o)
  );

  always #5 clock_i = ~clock_i;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          n_rd = 0, n_we = 0, n_ack = 0;
  bit          ack_seen;
  int          ack_at;
  logic [7:0]  ack_dout;
  int          rdy_delay = 1, rdy_cnt = 0;
  logic [22:0] rdy_addr = '0;
  logic [22:0] last_addr;
  logic [7:0]  last_din;
  logic [7:0]  sdram_mem [int];
  logic [7:0]  ref_mem [int];
  logic [30:0] exp_q [$];
  bit          grant_log [$];
  bit          log_en = 0, cpu_auto = 0, dl_auto = 0;
  int          dl_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: SDRAM responder, CPU requester and download writer all act on the falling edge.
  task automatic step();
    @(negedge clock_i);
    cyc++;
    mem_ready_i = 1'b0;
    if (rdy_cnt > 0) begin
      rdy_cnt--;
      if (rdy_cnt == 0) begin
        mem_ready_i = 1'b1;
        mem_dout_i  = sdram_mem.exists(int'(rdy_addr)) ? sdram_mem[int'(rdy_addr)] : 8'h00;
      end
    end
    if (mem_rd_o || mem_we_o) begin
      if (mem_rd_o) n_rd++;
      if (mem_we_o) n_we++;
      last_addr = mem_addr_o;
      last_din  = mem_din_o;
      if (log_en) grant_log.push_back(mem_addr_o[22]);
      if (mem_we_o) sdram_mem[int'(mem_addr_o)] = mem_din_o;
      if (mem_we_o && mem_addr_o[22]) begin
        chk("dl_cmd_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("dl_cmd", {mem_addr_o, mem_din_o}, exp_q.pop_front());
      end
      rdy_addr = mem_addr_o;
      rdy_cnt  = rdy_delay;
    end
    if (cpu_ack_o) begin
      n_ack++;
      ack_seen = 1;
      ack_at   = cyc;
      ack_dout = cpu_dout_o;
      if (cpu_auto) begin
        cpu_addr_i = 23'h100000 + 23'(n_ack & 7);
        cpu_rd_i   = 1'b1;
        cpu_wr_i   = 1'b0;
      end else begin
        cpu_rd_i = 1'b0;
        cpu_wr_i = 1'b0;
      end
    end
    if (dl_auto) begin
      dl_wr_i = !dl_busy_o;
      if (!dl_busy_o) begin
        dl_addr_i = 23'h400000 + 23'(dl_n);
        dl_data_i = 8'(dl_n);
        exp_q.push_back({dl_addr_i, dl_data_i});
        dl_n++;
      end
    end
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    cpu_rd_i  = 1'b0;
    cpu_wr_i  = 1'b0;
    dl_wr_i   = 1'b0;
    cpu_auto  = 0;
    dl_auto   = 0;
    step();
    step();
    exp_q.delete();
    reset_n_i = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ack"},   cpu_ack_o,   0);
    chk({tag, "_dout"},  cpu_dout_o,  0);
    chk({tag, "_busy"},  dl_busy_o,   0);
    chk({tag, "_maddr"}, mem_addr_o,  0);
    chk({tag, "_mdin"},  mem_din_o,   0);
    chk({tag, "_mrd"},   mem_rd_o,    0);
    chk({tag, "_mwe"},   mem_we_o,    0);
    chk({tag, "_err"},   err_o,       0);
    chk({tag, "_ovf"},   ovf_o,       0);
    chk({tag, "_state"}, dbg_state_o, IDLE);
  endtask

  // Single CPU access; dly = cycles from strobe to ready, 0 = SDRAM never answers.
  task automatic cpu_op(input string tag, input bit rd, input bit wr, input logic [22:0] a,
                        input logic [7:0] d, input int dly);
    int         rd0, we0, req_at, exp_lat;
    logic [7:0] exp_d;
    step();
    rd0        = n_rd;
    we0        = n_we;
    ack_seen   = 0;
    rdy_delay  = dly;
    cpu_addr_i = a;
    cpu_din_i  = d;
    cpu_rd_i   = rd;
    cpu_wr_i   = wr;
    req_at     = cyc;
    for (int i = 0; i < 200 && !ack_seen; i++) step();
    exp_lat = (dly == 0) ? 2 + TMO : 2 + dly;
    chk({tag, "_acked"},   ack_seen, 1);
    chk({tag, "_latency"}, ack_at - req_at, exp_lat);
    chk({tag, "_n_rd"},    n_rd - rd0, wr ? 0 : 1);
    chk({tag, "_n_we"},    n_we - we0, wr ? 1 : 0);
    chk({tag, "_addr"},    last_addr, a);
    if (wr) begin
      chk({tag, "_din"}, last_din, d);
      ref_mem[int'(a)] = d;
    end else begin
      exp_d = (dly == 0) ? 8'hFF : (ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00);
      chk({tag, "_dout"}, ack_dout, exp_d);
    end
  endtask

  initial begin
    int a0, s0;
    // Reset state
    do_reset();
    chk_idle("rst");

    // Round-robin: both pending right after reset, CPU first, then alternating
    step();
    dl_addr_i = 23'h400000;
    dl_data_i = 8'h00;
    dl_wr_i   = 1'b1;
    exp_q.push_back({dl_addr_i, dl_data_i});
    dl_n = 1;
    step();
    dl_wr_i    = 1'b0;
    cpu_addr_i = 23'h100000;
    cpu_rd_i   = 1'b1;
    rdy_delay  = 2;
    cpu_auto   = 1;
    dl_auto    = 1;
    log_en     = 1;
    grant_log.delete();
    for (int i = 0; i < 300 && grant_log.size() < 6; i++) step();
    cpu_auto = 0;
    dl_auto  = 0;
    log_en   = 0;
    dl_wr_i  = 1'b0;
    chk("rr_count", grant_log.size() >= 6, 1);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_grant_%0d", i), grant_log[i], i % 2);
    for (int i = 0; i < 100; i++) step();
    chk("rr_drained", exp_q.size(), 0);

    // Basic read, then read+write collision (write wins, dout held)
    sdram_mem[32'h1234] = 8'hA5;
    ref_mem[32'h1234]   = 8'hA5;
    cpu_op("t1_read", 1, 0, 23'h001234, 8'h00, 1);
    cpu_op("t2_rdwr", 1, 1, 23'h000200, 8'h3C, 1);
    chk("t2_dout_held", cpu_dout_o, 8'hA5);

    // Randomized CPU traffic against the reference memory
    for (int i = 0; i < 10; i++) begin
      bit w;
      w = 1'($urandom_range(0, 1));
      cpu_op($sformatf("rnd%0d", i), !w, w, 23'h100000 + 23'($urandom_range(0, 7)),
             8'($urandom), $urandom_range(1, 6));
    end

    // Download burst into a slow SDRAM: bytes beyond the buffer are dropped
    do_reset();
    step();
    rdy_delay = 8;
    chk("t4_ovf_pre", ovf_o, 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t4_busy_%0d", i), dl_busy_o, i >= BUF);
      dl_addr_i = 23'h400100 + 23'(i);
      dl_data_i = 8'h60 + 8'(i);
      dl_wr_i   = 1'b1;
      if (i < BUF) exp_q.push_back({dl_addr_i, dl_data_i});
      step();
    end
    dl_wr_i = 1'b0;
    chk("t4_ovf", ovf_o, 1);
    for (int i = 0; i < 120; i++) step();
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_busy_end", dl_busy_o, 0);
    chk("t4_ovf_sticky", ovf_o, 1);

    // Timeout on a read, err_o sticky across a later good access
    cpu_op("t5_timeout", 1, 0, 23'h100020, 8'h00, 0);
    chk("t5_err", err_o, 1);
    cpu_op("t5_after", 0, 1, 23'h100021, 8'h5A, 3);
    chk("t5_err_sticky", err_o, 1);
    chk("t5_dout_held", cpu_dout_o, 8'hFF);

    // Reset during WAIT with buffered bytes; the late ready must be ignored
    step();
    rdy_delay = 10;
    for (int i = 0; i < 3; i++) begin
      dl_addr_i = 23'h400200 + 23'(i);
      dl_data_i = 8'h90 + 8'(i);
      dl_wr_i   = 1'b1;
      if (i < BUF) exp_q.push_back({dl_addr_i, dl_data_i});
      step();
    end
    dl_wr_i = 1'b0;
    chk("t6_in_wait", dbg_state_o, WAIT);
    chk("t6_busy_pre", dl_busy_o, 3 >= BUF);
    reset_n_i = 1'b0;
    step();
    chk_idle("t6");
    reset_n_i = 1'b1;
    exp_q.delete();
    a0 = n_ack;
    s0 = n_rd + n_we;
    for (int i = 0; i < 25; i++) step();
    chk("t6_no_ack", n_ack, a0);
    chk("t6_no_cmd", n_rd + n_we, s0);
    chk("t6_busy_post", dl_busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
